// File: rtl/led_frame_scheduler_pkg.sv
// Purpose : shared types and defaults for the LED frame scheduler.
//   - sched_state_e : scheduler FSM state encoding (3 bits)
//   - *Default      : default divider / watchdog / counter-width constants
//   - is_active()   : true while a frame owns the ship engine (watchdog runs)
package led_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLaunch  = 3'd1,
    StShip    = 3'd2,
    StRelease = 3'd3,
    StFault   = 3'd4
  } sched_state_e;

  // 60 Hz refresh at 100 MHz
  localparam int unsigned RefreshDivDefault = 1_666_667;
  localparam int unsigned TimeoutCycDefault = 2_000_000;
  localparam int unsigned FcntWDefault      = 16;

  function automatic logic is_active(sched_state_e s);
    return (s == StLaunch) || (s == StShip) || (s == StRelease);
  endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Purpose : bundles the scheduler's game-logic and ship-engine handshakes.
//   enable, upd_req, upd_ack      : game logic refresh enable / frame request / ack
//   buf_lock                      : pixel memory locked while a frame ships
//   go, ready2go                  : launch handshake with the ship controller
//   all_done                      : GRB engine finished (reset code sent)
//   frame_cnt, timeout_err, err_clr : status counter, sticky fault flag, fault clear
// Modports: slave = scheduler side, master = surrounding system side.
interface led_frame_scheduler_if #(
  parameter int unsigned FCNT_W = led_frame_scheduler_pkg::FcntWDefault
);

  logic              enable;
  logic              upd_req;
  logic              upd_ack;
  logic              buf_lock;
  logic              go;
  logic              ready2go;
  logic              all_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              timeout_err;
  logic              err_clr;

  modport slave (
    input  enable,
    input  upd_req,
    input  ready2go,
    input  all_done,
    input  err_clr,
    output upd_ack,
    output buf_lock,
    output go,
    output frame_cnt,
    output timeout_err
  );

  modport master (
    output enable,
    output upd_req,
    output ready2go,
    output all_done,
    output err_clr,
    input  upd_ack,
    input  buf_lock,
    input  go,
    input  frame_cnt,
    input  timeout_err
  );

endinterface

// File: rtl/led_tick_div.sv
// Purpose : free-running refresh divider; one-cycle tick every DIV enabled cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_enable   : 1 = count; 0 = counter held at zero
//   o_tick     : high for the cycle in which the DIV-th enabled cycle completes
module led_tick_div #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_enable || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_tick = i_enable & w_wrap;

endmodule

// File: rtl/led_frame_scheduler.sv
// Purpose : sequences LED-strip frame transmission. Arbitrates the periodic
//   refresh tick against game-logic update requests, drives the go/ready2go
//   launch handshake, locks pixel memory while a frame ships, counts completed
//   frames and trips a watchdog if the ship engine hangs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : led_frame_scheduler_if.slave (enable, upd_req/upd_ack, buf_lock,
//                go/ready2go, all_done, frame_cnt, timeout_err/err_clr)
module led_frame_scheduler
  import led_frame_scheduler_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = RefreshDivDefault,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault,
  parameter int unsigned FCNT_W      = FcntWDefault
) (
  input logic                  clk,
  input logic                  rst_n,
  led_frame_scheduler_if.slave bus
);

  localparam int unsigned WdogW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_e      r_state;
  logic              r_pend_ref;
  logic              r_is_upd;
  logic              r_go;
  logic              r_buf_lock;
  logic              r_upd_ack;
  logic              r_timeout_err;
  logic [WdogW-1:0]  r_wdog;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic w_tick;
  logic w_launch;
  logic w_wdog_expired;

  led_tick_div #(
    .DIV (REFRESH_DIV)
  ) u_tick_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (bus.enable),
    .o_tick   (w_tick)
  );

  // Launch only when the ship controller is idle, so a frame still in the
  // engine after a reset is never re-triggered.
  assign w_launch = (r_state == StIdle) & bus.ready2go & (bus.upd_req | r_pend_ref);

  // Compare against TIMEOUT_CYC-1 so the counter fits in $clog2(TIMEOUT_CYC)
  // bits; the frame has then spent exactly TIMEOUT_CYC cycles in flight.
  assign w_wdog_expired = is_active(r_state) && (r_wdog == WdogW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_pend_ref    <= 1'b0;
      r_is_upd      <= 1'b0;
      r_go          <= 1'b0;
      r_buf_lock    <= 1'b0;
      r_upd_ack     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wdog        <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_upd_ack <= 1'b0;

      // A launch consumes any pending refresh, including a tick that lands on
      // the launch cycle itself; extra ticks coalesce into one pending bit.
      if (w_launch) begin
        r_pend_ref <= 1'b0;
      end else if (w_tick) begin
        r_pend_ref <= 1'b1;
      end

      // Set beats clear when both happen on the same cycle.
      if (w_wdog_expired) begin
        r_timeout_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_timeout_err <= 1'b0;
      end

      if (is_active(r_state)) begin
        r_wdog <= r_wdog + WdogW'(1);
      end

      if (w_wdog_expired) begin
        // Abandon the frame: no count, no ack; a held upd_req retries later.
        r_state    <= StFault;
        r_go       <= 1'b0;
        r_buf_lock <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_launch) begin
              r_state    <= StLaunch;
              r_is_upd   <= bus.upd_req;
              r_go       <= 1'b1;
              r_buf_lock <= 1'b1;
              r_wdog     <= '0;
            end
          end
          StLaunch: begin
            if (!bus.ready2go) begin
              r_state <= StShip;
            end
          end
          StShip: begin
            if (bus.all_done) begin
              r_state     <= StRelease;
              r_go        <= 1'b0;
              r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
              r_upd_ack   <= r_is_upd;
            end
          end
          StRelease: begin
            // Memory stays locked until the ship controller finishes its
            // own debounce and reports idle again.
            if (bus.ready2go) begin
              r_state    <= StIdle;
              r_buf_lock <= 1'b0;
            end
          end
          StFault: begin
            if (bus.ready2go) begin
              r_state <= StIdle;
            end
          end
          default: begin
            r_state    <= StIdle;
            r_go       <= 1'b0;
            r_buf_lock <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.go          = r_go;
  assign bus.buf_lock    = r_buf_lock;
  assign bus.upd_ack     = r_upd_ack;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_led_frame_scheduler.sv
module tb_led_frame_scheduler;

  localparam int unsigned REFRESH_DIV = 100;
  localparam int unsigned TIMEOUT_CYC = 500;
  localparam int unsigned FCNT_W      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_frame_scheduler_if #(.FCNT_W(FCNT_W)) bus ();

  led_frame_scheduler #(
    .REFRESH_DIV (REFRESH_DIV),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FCNT_W      (FCNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;   // frames the bench expects to have completed since reset

  // Ship controller / GRB engine model
  bit m_hang       = 1'b0;
  bit m_force_idle = 1'b0;
  int m_phase      = 0;
  int m_wait       = 0;

  initial begin
    bus.ready2go = 1'b1;
    bus.all_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.all_done = 1'b0;
      if (m_force_idle) begin
        m_phase      = 0;
        bus.ready2go = 1'b1;
      end else begin
        case (m_phase)
          0: if (bus.go) begin m_wait = $urandom_range(0, 3); m_phase = 1; end
          1: begin
            if (m_wait == 0) begin
              bus.ready2go = 1'b0;
              m_wait       = $urandom_range(5, 30);
              m_phase      = 2;
            end else m_wait--;
          end
          2: begin
            if (!m_hang) begin
              if (m_wait == 0) begin bus.all_done = 1'b1; m_phase = 3; end
              else m_wait--;
            end
          end
          3: if (!bus.go) begin m_wait = $urandom_range(1, 4); m_phase = 4; end
          4: begin
            if (m_wait == 0) begin bus.ready2go = 1'b1; m_phase = 0; end
            else m_wait--;
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Event monitor: counts ack pulses and go rising edges.
  int n_ack    = 0;
  int n_launch = 0;
  bit prev_go  = 1'b0;
  always @(negedge clk) begin
    if (bus.upd_ack === 1'b1) n_ack++;
    if (bus.go === 1'b1 && !prev_go) n_launch++;
    prev_go = (bus.go === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_quiet(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge clk);
      if (bus.buf_lock === 1'b0 && bus.go === 1'b0 && bus.ready2go === 1'b1) ok = 1'b1;
    end
  endtask

  // Holds upd_req until the ack pulse, then drops it.
  task automatic run_upd_frame(input int bound, output bit got_ack);
    got_ack     = 1'b0;
    bus.upd_req = 1'b1;
    for (int c = 0; c < bound && !got_ack; c++) begin
      @(negedge clk);
      if (bus.upd_ack === 1'b1) got_ack = 1'b1;
    end
    bus.upd_req = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable  = 1'b0;
    bus.upd_req = 1'b0;
    bus.err_clr = 1'b0;
    rst_n       = 1'b0;
    cycles(3);
    n_checks++;
    if ({bus.go, bus.buf_lock, bus.upd_ack, bus.timeout_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got go/lock/ack/err=%b want 0000",
               {bus.go, bus.buf_lock, bus.upd_ack, bus.timeout_err});
    end
    n_checks++;
    if (bus.frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt);
    end
    rst_n   = 1'b1;
    exp_cnt = 0;
    cycles(2);
  endtask

  task automatic test_refresh();
    int ack0, launch0, enabled;
    bit ok;
    ack0     = n_ack;
    launch0  = n_launch;
    enabled  = 1000;
    bus.enable = 1'b1;
    cycles(enabled);
    bus.enable = 1'b0;
    cycles(5);
    wait_quiet(300, ok);
    cycles(3);
    exp_cnt += enabled / REFRESH_DIV;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL refresh_quiet: got busy want idle"); end
    n_checks++;
    if (bus.frame_cnt !== FCNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL refresh_frame_cnt: got %0d want %0d", bus.frame_cnt, FCNT_W'(exp_cnt));
    end
    n_checks++;
    if (n_launch - launch0 != enabled / REFRESH_DIV) begin
      n_fail++;
      $display("FAIL refresh_launches: got %0d want %0d", n_launch - launch0,
               enabled / REFRESH_DIV);
    end
    n_checks++;
    if (n_ack != ack0) begin
      n_fail++;
      $display("FAIL refresh_no_ack: got %0d acks want 0", n_ack - ack0);
    end
  endtask

  task automatic test_update();
    for (int it = 0; it < 6; it++) begin
      int  acks, lock_bad;
      bit  done, seen_ack, prev_r2g;
      cycles($urandom_range(1, 20));
      bus.upd_req = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.go !== 1'b1 || bus.buf_lock !== 1'b1) begin
        n_fail++;
        $display("FAIL upd_latency[%0d]: got go=%b lock=%b want 1/1", it, bus.go, bus.buf_lock);
      end
      acks = 0; lock_bad = 0; done = 1'b0; seen_ack = 1'b0; prev_r2g = bus.ready2go;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (bus.upd_ack === 1'b1) begin
          acks++;
          seen_ack    = 1'b1;
          bus.upd_req = 1'b0;
        end
        if (bus.buf_lock !== 1'b1) begin
          if (!seen_ack || !prev_r2g) lock_bad++;
          done = 1'b1;
        end
        prev_r2g = bus.ready2go;
      end
      bus.upd_req = 1'b0;
      cycles(3);
      if (bus.upd_ack === 1'b1) acks++;
      exp_cnt++;
      n_checks++;
      if (!done || lock_bad != 0) begin
        n_fail++;
        $display("FAIL upd_buf_lock[%0d]: got done=%0b early_release=%0d want 1/0",
                 it, done, lock_bad);
      end
      n_checks++;
      if (acks != 1) begin
        n_fail++;
        $display("FAIL upd_ack_once[%0d]: got %0d acks want 1", it, acks);
      end
      n_checks++;
      if (bus.frame_cnt !== FCNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL upd_frame_cnt[%0d]: got %0d want %0d", it, bus.frame_cnt,
                 FCNT_W'(exp_cnt));
      end
    end
  endtask

  task automatic test_tick_and_upd();
    int ack0, launch0;
    bit got_ack, ok;
    ack0    = n_ack;
    launch0 = n_launch;
    // Divider is at zero (enable was low); the REFRESH_DIV-th enabled edge ticks.
    bus.enable = 1'b1;
    cycles(REFRESH_DIV - 1);
    bus.upd_req = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
    n_checks++;
    if (bus.go !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_upd_go: got %b want 1", bus.go);
    end
    run_upd_frame(200, got_ack);
    wait_quiet(200, ok);
    cycles(150);
    exp_cnt++;
    n_checks++;
    if (!got_ack || !ok || n_ack - ack0 != 1) begin
      n_fail++;
      $display("FAIL tick_upd_ack: got ack=%0b quiet=%0b acks=%0d want 1/1/1",
               got_ack, ok, n_ack - ack0);
    end
    n_checks++;
    if (n_launch - launch0 != 1) begin
      n_fail++;
      $display("FAIL tick_upd_single_frame: got %0d launches want 1", n_launch - launch0);
    end
    n_checks++;
    if (bus.frame_cnt !== FCNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL tick_upd_frame_cnt: got %0d want %0d", bus.frame_cnt, FCNT_W'(exp_cnt));
    end
  endtask

  task automatic test_timeout();
    int  ack0, go_cycles;
    bit  fell, got_ack, ok;
    ack0   = n_ack;
    m_hang = 1'b1;
    bus.upd_req = 1'b1;
    go_cycles = 0;
    fell      = 1'b0;
    for (int c = 0; c < 1000 && !fell; c++) begin
      @(negedge clk);
      if (bus.go === 1'b1) go_cycles++;
      else fell = 1'b1;
    end
    n_checks++;
    if (!fell || go_cycles != TIMEOUT_CYC) begin
      n_fail++;
      $display("FAIL timeout_cycles: got fell=%0b go_cycles=%0d want 1/%0d",
               fell, go_cycles, TIMEOUT_CYC);
    end
    n_checks++;
    if ({bus.timeout_err, bus.go, bus.buf_lock} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_flags: got err/go/lock=%b want 100",
               {bus.timeout_err, bus.go, bus.buf_lock});
    end
    n_checks++;
    if (bus.frame_cnt !== FCNT_W'(exp_cnt) || n_ack != ack0) begin
      n_fail++;
      $display("FAIL timeout_no_count: got cnt=%0d acks=%0d want %0d/0",
               bus.frame_cnt, n_ack - ack0, FCNT_W'(exp_cnt));
    end
    cycles(3);
    n_checks++;
    if (bus.timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %b want 1", bus.timeout_err);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    n_checks++;
    if (bus.timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err_clr: got %b want 0", bus.timeout_err);
    end
    // Engine recovers; the still-held request must be retried and complete.
    m_hang       = 1'b0;
    m_force_idle = 1'b1;
    @(negedge clk);
    m_force_idle = 1'b0;
    run_upd_frame(300, got_ack);
    wait_quiet(200, ok);
    exp_cnt++;
    n_checks++;
    if (!got_ack || !ok || bus.frame_cnt !== FCNT_W'(exp_cnt) || bus.timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_retry: got ack=%0b quiet=%0b cnt=%0d err=%b want 1/1/%0d/0",
               got_ack, ok, bus.frame_cnt, bus.timeout_err, FCNT_W'(exp_cnt));
    end
  endtask

  task automatic test_reset_mid();
    bit busy, got_ack, ok;
    int go_seen, launch0;
    m_hang      = 1'b1;
    bus.upd_req = 1'b1;
    busy = 1'b0;
    for (int c = 0; c < 20 && !busy; c++) begin
      @(negedge clk);
      if (bus.go === 1'b1 && bus.ready2go === 1'b0) busy = 1'b1;
    end
    cycles(3);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++;
    if (!busy || {bus.go, bus.buf_lock, bus.upd_ack, bus.timeout_err} !== 4'b0000
        || bus.frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%0b go/lock/ack/err=%b cnt=%0d want 1/0000/0",
               busy, {bus.go, bus.buf_lock, bus.upd_ack, bus.timeout_err}, bus.frame_cnt);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    launch0 = n_launch;
    go_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.go !== 1'b0) go_seen++;
    end
    n_checks++;
    if (go_seen != 0) begin
      n_fail++;
      $display("FAIL midreset_no_retrigger: got go high %0d cycles want 0", go_seen);
    end
    m_hang       = 1'b0;
    m_force_idle = 1'b1;
    @(negedge clk);
    m_force_idle = 1'b0;
    run_upd_frame(300, got_ack);
    wait_quiet(200, ok);
    exp_cnt++;
    n_checks++;
    if (!got_ack || !ok || n_launch - launch0 != 1 || bus.frame_cnt !== FCNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL midreset_resume: got ack=%0b quiet=%0b launches=%0d cnt=%0d want 1/1/1/%0d",
               got_ack, ok, n_launch - launch0, bus.frame_cnt, FCNT_W'(exp_cnt));
    end
  endtask

  task automatic test_wrap();
    bit got_ack, ok;
    for (int f = 0; f < (1 << FCNT_W); f++) begin
      cycles($urandom_range(1, 5));
      run_upd_frame(300, got_ack);
      wait_quiet(200, ok);
      exp_cnt++;
      n_checks++;
      if (!got_ack || !ok || bus.frame_cnt !== FCNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL wrap_frame_cnt[%0d]: got ack=%0b quiet=%0b cnt=%0d want 1/1/%0d",
                 f, got_ack, ok, bus.frame_cnt, FCNT_W'(exp_cnt));
      end
    end
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_update();
    test_tick_and_upd();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running at 2 ms, want finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
